obi_bus_arbiter: RTL and testbench

OBI_BUS_ARBITER -- requirements
Module: obi_bus_arbiter

---
 rtl/obi_bus_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_obi_bus_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_bus_arbiter.sv
// OBI N-master to M-slave arbiter with a single outstanding transaction.
// Fixed-priority or round-robin arbitration, address-decoded slave select.
module obi_bus_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int SEL_LSB     = 19,
  parameter int SEL_WIDTH   = 4,
  parameter int ARB_MODE    = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NUM_MASTERS-1:0]           m_req_i,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr_i,
  input  logic [NUM_MASTERS-1:0]           m_we_i,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be_i,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata_i,
  output logic [NUM_MASTERS-1:0]           m_gnt_o,
  output logic [NUM_MASTERS-1:0]           m_rvalid_o,
  output logic [NUM_MASTERS-1:0]           m_err_o,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata_o,
  output logic [NUM_SLAVES-1:0]            s_req_o,
  output logic [ADDR_WIDTH-1:0]            s_addr_o,
  output logic                             s_we_o,
  output logic [DATA_WIDTH/8-1:0]          s_be_o,
  output logic [DATA_WIDTH-1:0]            s_wdata_o,
  input  logic [NUM_SLAVES-1:0]            s_gnt_i,
  input  logic [NUM_SLAVES-1:0]            s_rvalid_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  output logic                             busy_o
);

  localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ADDR, RESP} state_e;

  state_e                state_q;
  logic [MW-1:0]         rr_q;
  logic [MW-1:0]         mst_q;
  logic [SW-1:0]         sidx_q;
  logic                  err_q;
  logic                  cool_q;

  logic [MW-1:0]         idx;
  logic [MW-1:0]         win;
  logic                  found;
  logic [MW-1:0]         cur_m;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic                  cur_we;
  logic [BW-1:0]         cur_be;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [SEL_WIDTH-1:0]  sel;
  logic [SW-1:0]         sidx;
  logic                  dec_err;
  logic [DATA_WIDTH-1:0] rsp_data;

  // Pick the winning master; round-robin scans upward from rr_q.
  always_comb begin
    idx   = '0;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (ARB_MODE == 1) begin
        idx = MW'((int'(rr_q) + i) % NUM_MASTERS);
      end else begin
        idx = MW'(i);
      end
      if (!found && m_req_i[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Mux the active master onto the shared bus and decode its slave.
  always_comb begin
    cur_m     = (state_q == IDLE) ? win : mst_q;
    cur_addr  = '0;
    cur_we    = 1'b0;
    cur_be    = '0;
    cur_wdata = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (MW'(i) == cur_m) begin
        cur_addr  = m_addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        cur_we    = m_we_i[i];
        cur_be    = m_be_i[i*BW +: BW];
        cur_wdata = m_wdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    sel     = cur_addr[SEL_LSB +: SEL_WIDTH];
    dec_err = 32'(sel) >= NUM_SLAVES;
    sidx    = SW'(sel);
    rsp_data = '0;
    for (int j = 0; j < NUM_SLAVES; j++) begin
      if (SW'(j) == sidx_q) begin
        rsp_data = s_rdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Handshake outputs; IDLE terms are gated so reset forces them low.
  always_comb begin
    s_addr_o   = cur_addr;
    s_we_o     = cur_we;
    s_be_o     = cur_be;
    s_wdata_o  = cur_wdata;
    s_req_o    = '0;
    m_gnt_o    = '0;
    m_rvalid_o = '0;
    m_err_o    = '0;
    m_rdata_o  = '0;
    busy_o     = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (rst_ni && !cool_q && found) begin
          if (dec_err) begin
            m_gnt_o = NUM_MASTERS'(1) << win;
          end else begin
            s_req_o = NUM_SLAVES'(1) << sidx;
            if (s_gnt_i[sidx]) m_gnt_o = NUM_MASTERS'(1) << win;
          end
        end
      end
      ADDR: begin
        s_req_o = NUM_SLAVES'(1) << sidx_q;
        if (s_gnt_i[sidx_q]) m_gnt_o = NUM_MASTERS'(1) << mst_q;
      end
      RESP: begin
        if (err_q) begin
          m_rvalid_o = NUM_MASTERS'(1) << mst_q;
          m_err_o    = NUM_MASTERS'(1) << mst_q;
        end else if (s_rvalid_i[sidx_q]) begin
          m_rvalid_o = NUM_MASTERS'(1) << mst_q;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            if (MW'(i) == mst_q) begin
              m_rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = rsp_data;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM, lock registers and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rr_q    <= '0;
      mst_q   <= '0;
      sidx_q  <= '0;
      err_q   <= 1'b0;
      cool_q  <= 1'b0;
    end else begin
      cool_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!cool_q && found) begin
            mst_q  <= win;
            sidx_q <= sidx;
            err_q  <= dec_err;
            if (dec_err || s_gnt_i[sidx]) begin
              state_q <= RESP;
              rr_q    <= MW'((int'(win) + 1) % NUM_MASTERS);
            end else begin
              state_q <= ADDR;
            end
          end
        end
        ADDR: begin
          if (s_gnt_i[sidx_q]) begin
            state_q <= RESP;
            rr_q    <= MW'((int'(mst_q) + 1) % NUM_MASTERS);
          end
        end
        RESP: begin
          if (err_q || s_rvalid_i[sidx_q]) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
            cool_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_obi_bus_arbiter.sv
// Directed bench for obi_bus_arbiter: round-robin and fixed instances
// share stimulus; expected values are hand-computed per step.
module tb_obi_bus_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [1:0]  m_req_i;
  logic [63:0] m_addr_i;
  logic [1:0]  m_we_i;
  logic [7:0]  m_be_i;
  logic [63:0] m_wdata_i;
  logic [2:0]  s_gnt_i;
  logic [2:0]  s_rvalid_i;
  logic [95:0] s_rdata_i;

  logic [1:0]  m_gnt_o, m_rvalid_o, m_err_o;
  logic [63:0] m_rdata_o;
  logic [2:0]  s_req_o;
  logic [31:0] s_addr_o;
  logic        s_we_o;
  logic [3:0]  s_be_o;
  logic [31:0] s_wdata_o;
  logic        busy_o;

  logic [1:0]  fx_gnt, fx_rvalid, fx_err;
  logic [63:0] fx_rdata;
  logic [2:0]  fx_sreq;
  logic [31:0] fx_saddr;
  logic        fx_swe;
  logic [3:0]  fx_sbe;
  logic [31:0] fx_swdata;
  logic        fx_busy;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  obi_bus_arbiter #(.ARB_MODE(1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(m_gnt_o), .m_rvalid_o(m_rvalid_o), .m_err_o(m_err_o),
    .m_rdata_o(m_rdata_o), .s_req_o(s_req_o), .s_addr_o(s_addr_o),
    .s_we_o(s_we_o), .s_be_o(s_be_o), .s_wdata_o(s_wdata_o),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .busy_o(busy_o)
  );

  obi_bus_arbiter #(.ARB_MODE(0)) dut_fx (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m_req_i(m_req_i), .m_addr_i(m_addr_i), .m_we_i(m_we_i),
    .m_be_i(m_be_i), .m_wdata_i(m_wdata_i),
    .m_gnt_o(fx_gnt), .m_rvalid_o(fx_rvalid), .m_err_o(fx_err),
    .m_rdata_o(fx_rdata), .s_req_o(fx_sreq), .s_addr_o(fx_saddr),
    .s_we_o(fx_swe), .s_be_o(fx_sbe), .s_wdata_o(fx_swdata),
    .s_gnt_i(s_gnt_i), .s_rvalid_i(s_rvalid_i), .s_rdata_i(s_rdata_i),
    .busy_o(fx_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni     = 1'b0;
    m_req_i    = '0;
    m_addr_i   = '0;
    m_we_i     = '0;
    m_be_i     = '0;
    m_wdata_i  = '0;
    s_gnt_i    = '0;
    s_rvalid_i = '0;
    s_rdata_i  = '0;
    #2;
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_gnt", 64'(m_gnt_o), 64'd0);
    chk("rst_sreq", 64'(s_req_o), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid_o), 64'd0);
    tick();
    rst_ni = 1'b1;

    // round-robin vs fixed priority, both masters always requesting
    m_req_i    = 2'b11;
    m_addr_i   = {32'h0000_0004, 32'h0000_0000};
    s_gnt_i    = 3'b111;
    s_rvalid_i = 3'b111;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_gnt", 64'(m_gnt_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("fx_gnt", 64'(fx_gnt), 64'd1);
      tick();
      #1;
      chk("rr_rvalid", 64'(m_rvalid_o), (k % 2 == 0) ? 64'd1 : 64'd2);
      chk("rr_resp_gnt", 64'(m_gnt_o), 64'd0);
      tick();
      #1;
      chk("rr_cool_gnt", 64'(m_gnt_o), 64'd0);
      tick();
    end
    m_req_i    = '0;
    s_gnt_i    = '0;
    s_rvalid_i = '0;

    // single read M0 -> S0
    m_req_i  = 2'b01;
    m_addr_i = {32'h0, 32'h0000_0010};
    s_gnt_i  = 3'b001;
    #1;
    chk("rd_gnt", 64'(m_gnt_o), 64'd1);
    chk("rd_sreq", 64'(s_req_o), 64'd1);
    chk("rd_saddr", 64'(s_addr_o), 64'h10);
    tick();
    m_req_i    = '0;
    s_gnt_i    = '0;
    s_rvalid_i = 3'b001;
    s_rdata_i  = {64'h0, 32'hDEAD_BEEF};
    #1;
    chk("rd_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("rd_rdata", m_rdata_o, 64'h0000_0000_DEAD_BEEF);
    chk("rd_busy", 64'(busy_o), 64'd1);
    tick();
    s_rvalid_i = '0;
    #1;
    chk("rd_idle_busy", 64'(busy_o), 64'd0);
    tick();

    // stalled grant on S2 while M1 also requests
    m_req_i  = 2'b01;
    m_addr_i = {32'h0000_0020, 32'h0010_0004};
    #1;
    chk("st_sreq", 64'(s_req_o), 64'd4);
    chk("st_gnt0", 64'(m_gnt_o), 64'd0);
    tick();
    m_req_i = 2'b11;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("st_saddr", 64'(s_addr_o), 64'h0010_0004);
      chk("st_gnt_wait", 64'(m_gnt_o), 64'd0);
      chk("st_busy", 64'(busy_o), 64'd1);
      tick();
    end
    s_gnt_i = 3'b100;
    #1;
    chk("st_gnt", 64'(m_gnt_o), 64'd1);
    chk("st_saddr_g", 64'(s_addr_o), 64'h0010_0004);
    tick();
    m_req_i    = 2'b10;
    s_gnt_i    = 3'b001;
    s_rvalid_i = 3'b001;
    s_rdata_i  = {32'hCAFE_F00D, 32'h0, 32'h1111_1111};
    #1;
    chk("st_wrong_rv", 64'(m_rvalid_o), 64'd0);
    chk("st_resp_gnt", 64'(m_gnt_o), 64'd0);
    chk("st_resp_sreq", 64'(s_req_o), 64'd0);
    tick();
    s_rvalid_i = 3'b100;
    #1;
    chk("st_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("st_rdata", m_rdata_o, 64'h0000_0000_CAFE_F00D);
    tick();
    s_rvalid_i = '0;
    #1;
    chk("st_cool_gnt", 64'(m_gnt_o), 64'd0);
    tick();
    #1;
    chk("st_m1_gnt", 64'(m_gnt_o), 64'd2);
    chk("st_m1_saddr", 64'(s_addr_o), 64'h20);
    tick();
    m_req_i    = '0;
    s_gnt_i    = '0;
    s_rvalid_i = 3'b001;
    #1;
    chk("st_m1_rvalid", 64'(m_rvalid_o), 64'd2);
    chk("st_m1_rdata", m_rdata_o, 64'h1111_1111_0000_0000);
    tick();
    s_rvalid_i = '0;
    tick();

    // decode error, sidx 15
    m_req_i  = 2'b01;
    m_addr_i = {32'h0, 32'h0078_0000};
    s_gnt_i  = 3'b111;
    #1;
    chk("de_gnt", 64'(m_gnt_o), 64'd1);
    chk("de_sreq", 64'(s_req_o), 64'd0);
    tick();
    m_req_i = '0;
    s_gnt_i = '0;
    #1;
    chk("de_rvalid", 64'(m_rvalid_o), 64'd1);
    chk("de_err", 64'(m_err_o), 64'd1);
    chk("de_rdata", m_rdata_o, 64'd0);
    chk("de_sreq2", 64'(s_req_o), 64'd0);
    tick();
    #1;
    chk("de_err_clr", 64'(m_err_o), 64'd0);
    tick();

    // write M1 -> S1 with one stall cycle
    m_req_i   = 2'b10;
    m_addr_i  = {32'h0008_0000, 32'h0};
    m_we_i    = 2'b10;
    m_be_i    = 8'h30;
    m_wdata_i = {32'h1234_5678, 32'h0};
    #1;
    chk("wr_sreq", 64'(s_req_o), 64'd2);
    chk("wr_we", 64'(s_we_o), 64'd1);
    chk("wr_be", 64'(s_be_o), 64'h3);
    chk("wr_wdata", 64'(s_wdata_o), 64'h1234_5678);
    chk("wr_gnt0", 64'(m_gnt_o), 64'd0);
    tick();
    s_gnt_i = 3'b010;
    #1;
    chk("wr_gnt", 64'(m_gnt_o), 64'd2);
    chk("wr_be2", 64'(s_be_o), 64'h3);
    tick();
    m_req_i    = '0;
    m_we_i     = '0;
    m_be_i     = '0;
    s_gnt_i    = '0;
    s_rvalid_i = 3'b010;
    #1;
    chk("wr_rvalid", 64'(m_rvalid_o), 64'd2);
    tick();
    #1;
    chk("wr_rv_once", 64'(m_rvalid_o), 64'd0);
    tick();
    #1;
    chk("wr_rv_idle", 64'(m_rvalid_o), 64'd0);
    s_rvalid_i = '0;

    // reset pulse while in RESP
    m_req_i  = 2'b01;
    m_addr_i = {32'h0, 32'h0000_0040};
    s_gnt_i  = 3'b001;
    #1;
    chk("rs_gnt", 64'(m_gnt_o), 64'd1);
    tick();
    s_gnt_i = '0;
    #1;
    chk("rs_busy1", 64'(busy_o), 64'd1);
    rst_ni = 1'b0;
    #1;
    chk("rs_busy0", 64'(busy_o), 64'd0);
    chk("rs_gnt0", 64'(m_gnt_o), 64'd0);
    chk("rs_rvalid0", 64'(m_rvalid_o), 64'd0);
    chk("rs_err0", 64'(m_err_o), 64'd0);
    chk("rs_sreq0", 64'(s_req_o), 64'd0);
    tick();
    rst_ni     = 1'b1;
    m_req_i    = '0;
    s_rvalid_i = 3'b001;
    #1;
    chk("rs_late_rv", 64'(m_rvalid_o), 64'd0);
    chk("rs_late_busy", 64'(busy_o), 64'd0);
    tick();
    s_rvalid_i = '0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
